// File: rtl/hps_data_pkg.sv
// rtl/hps_data_pkg.sv - shared constants, state encoding and address helper for the HPS data RAM master
package hps_data_pkg;

  localparam int ADDR_W    = 2;
  localparam int DATA_W    = 128;
  localparam int BE_W      = DATA_W / 8;
  localparam int NUM_WORDS = 4;

  localparam logic [BE_W-1:0] BE_FULL = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_CMD,
    ST_RD_WAIT,
    ST_PRESENT,
    ST_WAIT_RES,
    ST_WR_CMD,
    ST_FINISH
  } hps_state_e;

  // Jobs may start anywhere and wrap past the last RAM word back to word 0.
  function automatic logic [ADDR_W-1:0] next_word(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(NUM_WORDS - 1)) ? '0 : a + ADDR_W'(1);
  endfunction

endpackage

// File: rtl/hps_data_stream_master_if.sv
// rtl/hps_data_stream_master_if.sv - job control, RAM port-2 and AES block/result signals
interface hps_data_stream_master_if;
  import hps_data_pkg::*;

  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   word_count;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [BE_W-1:0]   byteenable;
  logic              clken;
  logic [DATA_W-1:0] readdata;

  logic [DATA_W-1:0] blk_data;
  logic              blk_valid;
  logic              blk_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;

  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  start, base_addr, word_count, readdata, blk_ready, res_data, res_valid,
    output address, chipselect, write, writedata, byteenable, clken,
           blk_data, blk_valid, res_ready, busy, done, error
  );

  modport slave (
    output start, base_addr, word_count, readdata, blk_ready, res_data, res_valid,
    input  address, chipselect, write, writedata, byteenable, clken,
           blk_data, blk_valid, res_ready, busy, done, error
  );

endinterface

// File: rtl/hps_data_stream_master.sv
// rtl/hps_data_stream_master.sv - reads RAM blocks, streams them to the AES core, writes results back in place
module hps_data_stream_master
  import hps_data_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  hps_data_stream_master_if.master bus
);

  localparam logic [2:0] S_IDLE     = ST_IDLE;
  localparam logic [2:0] S_RD_CMD   = ST_RD_CMD;
  localparam logic [2:0] S_RD_WAIT  = ST_RD_WAIT;
  localparam logic [2:0] S_PRESENT  = ST_PRESENT;
  localparam logic [2:0] S_WAIT_RES = ST_WAIT_RES;
  localparam logic [2:0] S_WR_CMD   = ST_WR_CMD;
  localparam logic [2:0] S_FINISH   = ST_FINISH;

  localparam logic [ADDR_W:0] WC_MAX = (ADDR_W + 1)'(NUM_WORDS);
  localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_cur_addr;
  logic [ADDR_W:0]   r_remaining;
  logic [7:0]        r_lat_cnt;

  logic [ADDR_W-1:0] r_address;
  logic              r_chipselect;
  logic              r_write;
  logic [DATA_W-1:0] r_writedata;
  logic [BE_W-1:0]   r_byteenable;
  logic              r_clken;
  logic [DATA_W-1:0] r_blk_data;
  logic              r_blk_valid;
  logic              r_res_ready;
  logic              r_busy;
  logic              r_done;
  logic              r_error;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_remaining  <= '0;
      r_lat_cnt    <= '0;
      r_address    <= '0;
      r_chipselect <= 1'b0;
      r_write      <= 1'b0;
      r_writedata  <= '0;
      r_byteenable <= BE_FULL;
      r_clken      <= 1'b1;
      r_blk_data   <= '0;
      r_blk_valid  <= 1'b0;
      r_res_ready  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_cur_addr  <= bus.base_addr;
            r_remaining <= bus.word_count;
            r_busy      <= 1'b1;
            if (bus.word_count == '0 || bus.word_count > WC_MAX) begin
              r_done  <= 1'b1;
              r_error <= (bus.word_count > WC_MAX);
              r_state <= S_FINISH;
            end else begin
              r_chipselect <= 1'b1;
              r_write      <= 1'b0;
              r_address    <= bus.base_addr;
              r_state      <= S_RD_CMD;
            end
          end
        end
        // Arriving from a write, chipselect is low: spend one idle cycle before the read command.
        S_RD_CMD: begin
          if (r_chipselect) begin
            r_chipselect <= 1'b0;
            r_lat_cnt    <= 8'(READ_LATENCY - 1);
            r_state      <= S_RD_WAIT;
          end else begin
            r_chipselect <= 1'b1;
            r_write      <= 1'b0;
            r_address    <= r_cur_addr;
          end
        end
        S_RD_WAIT: begin
          if (r_lat_cnt == '0) begin
            r_blk_data  <= bus.readdata;
            r_blk_valid <= 1'b1;
            r_state     <= S_PRESENT;
          end else begin
            r_lat_cnt <= r_lat_cnt - 8'd1;
          end
        end
        S_PRESENT: begin
          if (bus.blk_ready) begin
            r_blk_valid <= 1'b0;
            r_res_ready <= 1'b1;
            r_state     <= S_WAIT_RES;
          end
        end
        S_WAIT_RES: begin
          if (bus.res_valid) begin
            r_writedata  <= bus.res_data;
            r_res_ready  <= 1'b0;
            r_chipselect <= 1'b1;
            r_write      <= 1'b1;
            r_address    <= r_cur_addr;
            r_state      <= S_WR_CMD;
          end
        end
        S_WR_CMD: begin
          r_chipselect <= 1'b0;
          r_write      <= 1'b0;
          r_cur_addr   <= next_word(r_cur_addr);
          r_remaining  <= r_remaining - WC_ONE;
          if (r_remaining == WC_ONE) begin
            r_done  <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_state <= S_RD_CMD;
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.address    = r_address;
  assign bus.chipselect = r_chipselect;
  assign bus.write      = r_write;
  assign bus.writedata  = r_writedata;
  assign bus.byteenable = r_byteenable;
  assign bus.clken      = r_clken;
  assign bus.blk_data   = r_blk_data;
  assign bus.blk_valid  = r_blk_valid;
  assign bus.res_ready  = r_res_ready;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;

endmodule

// File: tb/tb_hps_data_stream_master.sv
// tb/tb_hps_data_stream_master.sv - directed bench with a port-2 RAM model and a stub AES core
module tb_hps_data_stream_master;
  import hps_data_pkg::*;

  localparam logic [DATA_W-1:0] PT1  = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [DATA_W-1:0] CT1  = 128'h69C4E0D8_6A7B0430_D8CDB780_70B4C55A;
  localparam logic [DATA_W-1:0] JUNK = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

  typedef struct {
    int                cyc;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } bus_ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  hps_data_stream_master_if bus();
  hps_data_stream_master #(.READ_LATENCY(1)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // RAM port 2: registered address, unregistered q, one-cycle read latency.
  logic [DATA_W-1:0] ram [NUM_WORDS];
  logic [ADDR_W-1:0] ram_raddr = '0;
  logic              pl_en = 1'b0;
  logic [ADDR_W-1:0] pl_addr = '0;
  logic [DATA_W-1:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) begin
      ram[pl_addr] <= pl_data;
    end else if (bus.clken && bus.chipselect) begin
      if (bus.write) begin
        for (int b = 0; b < BE_W; b++)
          if (bus.byteenable[b]) ram[bus.address][8*b +: 8] <= bus.writedata[8*b +: 8];
      end else begin
        ram_raddr <= bus.address;
      end
    end
  end
  assign bus.readdata = ram[ram_raddr];

  int      cyc = 0;
  bus_ev_t bus_log[$];
  int      done_cnt = 0;
  int      cs_consec = 0;
  logic    prev_cs = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus.chipselect) begin
      bus_log.push_back('{cyc, bus.write, bus.address, bus.writedata});
      if (prev_cs) cs_consec++;
    end
    prev_cs = bus.chipselect;
    if (bus.done) done_cnt++;
  end

  function automatic logic [DATA_W-1:0] aes_stub(input logic [DATA_W-1:0] blk);
    return (blk === PT1) ? CT1 : ~blk;
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    pl_addr = a;
    pl_data = d;
    pl_en   = 1'b1;
    @(negedge clk);
    pl_en   = 1'b0;
  endtask

  logic [DATA_W-1:0] blk_q[$];
  int   t0, log_base, done_base, done_cyc, first_blk_cyc, blk_hs_cyc, res_hs_cyc;
  logic err_at_done;
  bit   bp_stable, early_ready_seen;

  task automatic run_job(input logic [ADDR_W-1:0] base, input logic [ADDR_W:0] wc,
                         input int res_delay, input int bp, input int restart_at);
    int cnt, bp_left;
    logic [DATA_W-1:0] held;
    bit held_ok, res_drop;
    cnt = 0; bp_left = bp; held = '0; held_ok = 0; res_drop = 0;
    log_base = bus_log.size(); done_base = done_cnt; blk_q.delete();
    done_cyc = -1; first_blk_cyc = -1; blk_hs_cyc = -1; res_hs_cyc = -1;
    err_at_done = 1'b0; bp_stable = 1; early_ready_seen = 0;
    bus.base_addr = base; bus.word_count = wc; bus.start = 1'b1;
    bus.blk_ready = (bp_left == 0);
    t0 = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    for (int n = 0; n < 300; n++) begin
      if (res_drop) begin bus.res_valid = 1'b0; res_drop = 0; end
      if (bus.done) begin done_cyc = cyc; err_at_done = bus.error; break; end
      if (n == restart_at) begin
        bus.start = 1'b1; bus.base_addr = base + ADDR_W'(2); bus.word_count = 1;
      end else begin
        bus.start = 1'b0;
      end
      bus.blk_ready = (bp_left == 0);
      if (bus.blk_valid) begin
        if (first_blk_cyc < 0) first_blk_cyc = cyc;
        if (bp_left > 0) begin
          if (!held_ok) begin held = bus.blk_data; held_ok = 1; end
          else if (bus.blk_data !== held) bp_stable = 0;
          if (bp_left == bp - 2) begin
            bus.res_valid = 1'b1; bus.res_data = JUNK;
            if (bus.res_ready) early_ready_seen = 1;
            res_drop = 1;
          end
          bp_left--;
        end
      end
      if (bus.blk_valid && bus.blk_ready) begin
        blk_q.push_back(bus.blk_data);
        if (blk_hs_cyc < 0) blk_hs_cyc = cyc;
        cnt = res_delay;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin bus.res_valid = 1'b1; bus.res_data = aes_stub(blk_q[$]); end
      end
      if (bus.res_valid && bus.res_ready) begin res_drop = 1; res_hs_cyc = cyc; end
      @(negedge clk);
    end
    if (done_cyc < 0) check("job_timeout", 0, 1);
    bus.start = 1'b0; bus.res_valid = 1'b0; bus.blk_ready = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctl"}, {bus.chipselect, bus.write, bus.blk_valid, bus.res_ready,
                          bus.busy, bus.done, bus.error, bus.clken}, 8'b0000_0001);
    check({tag, "_be"}, bus.byteenable, BE_FULL);
    check({tag, "_addr"}, bus.address, 0);
    check({tag, "_wdata"}, bus.writedata, 0);
    check({tag, "_blk"}, bus.blk_data, 0);
  endtask

  logic [DATA_W-1:0] wv [NUM_WORDS];
  logic [ADDR_W-1:0] exp_addr [8];

  initial begin
    int b, ok;
    wv[0] = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    wv[1] = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
    wv[2] = 128'h13579BDF_2468ACE0_DEADC0DE_CAFEF00D;
    wv[3] = 128'h0BADF00D_FEEDFACE_12345678_9ABCDEF0;
    bus.start = 1'b0; bus.base_addr = '0; bus.word_count = '0;
    bus.blk_ready = 1'b1; bus.res_valid = 1'b0; bus.res_data = '0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    // Single word with the known AES vector
    preload(2, PT1);
    run_job(2, 1, 5, 0, -1);
    b = log_base;
    check("t1_ncs", bus_log.size() - b, 2);
    if (bus_log.size() - b >= 2) begin
      check("t1_rd", {bus_log[b].wr, bus_log[b].addr}, 3'b0_10);
      check("t1_rd_cyc", bus_log[b].cyc, t0 + 1);
      check("t1_wr", {bus_log[b+1].wr, bus_log[b+1].addr}, 3'b1_10);
      check("t1_wr_data", bus_log[b+1].data, CT1);
      check("t1_wr_cyc", bus_log[b+1].cyc, res_hs_cyc + 1);
      check("t1_done_cyc", done_cyc, bus_log[b+1].cyc + 1);
    end
    check("t1_blk_cyc", first_blk_cyc, t0 + 3);
    check("t1_blk_data", (blk_q.size() > 0) ? blk_q[0] : '0, PT1);
    check("t1_err", err_at_done, 0);
    check("t1_ndone", done_cnt - done_base, 1);
    check("t1_ram", ram[2], CT1);
    check("t1_busy", bus.busy, 0);

    // Wrap-around over the whole RAM
    for (int i = 0; i < NUM_WORDS; i++) preload(ADDR_W'(i), wv[i]);
    run_job(3, 4, 2, 0, -1);
    exp_addr = '{2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2};
    b = log_base;
    check("wrap_ncs", bus_log.size() - b, 8);
    for (int i = 0; i < 8 && b + i < bus_log.size(); i++)
      check($sformatf("wrap_seq%0d", i), {bus_log[b+i].wr, bus_log[b+i].addr},
            {1'(i % 2), exp_addr[i]});
    check("wrap_nblk", blk_q.size(), 4);
    check("wrap_blk0", (blk_q.size() > 0) ? blk_q[0] : '0, wv[3]);
    check("wrap_ndone", done_cnt - done_base, 1);
    check("wrap_ram3", ram[3], ~wv[3]);
    check("wrap_ram0", ram[0], ~wv[0]);
    check("wrap_ram2", ram[2], ~wv[2]);

    // Back-pressure with an early result pulse
    preload(1, wv[1]);
    run_job(1, 1, 3, 10, -1);
    check("bp_stable", bp_stable, 1);
    check("bp_early_ready", early_ready_seen, 0);
    check("bp_hold_cycles", blk_hs_cyc - first_blk_cyc, 10);
    check("bp_blk", (blk_q.size() > 0) ? blk_q[0] : '0, wv[1]);
    check("bp_ram", ram[1], ~wv[1]);

    // Rejected jobs
    run_job(1, 0, 2, 0, -1);
    check("zero_ncs", bus_log.size() - log_base, 0);
    check("zero_err", err_at_done, 0);
    check("zero_done_cyc", done_cyc, t0 + 1);
    check("zero_ndone", done_cnt - done_base, 1);
    run_job(1, 5, 2, 0, -1);
    check("over_ncs", bus_log.size() - log_base, 0);
    check("over_err", err_at_done, 1);
    check("over_ndone", done_cnt - done_base, 1);

    // Start while busy is ignored
    for (int i = 0; i < 3; i++) preload(ADDR_W'(i), wv[i]);
    run_job(0, 3, 2, 0, 6);
    exp_addr = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};
    b = log_base;
    check("busy_ncs", bus_log.size() - b, 6);
    for (int i = 0; i < 6 && b + i < bus_log.size(); i++)
      check($sformatf("busy_seq%0d", i), {bus_log[b+i].wr, bus_log[b+i].addr},
            {1'(i % 2), exp_addr[i]});
    check("busy_ndone", done_cnt - done_base, 1);
    check("busy_ram0", ram[0], ~wv[0]);
    check("busy_ram2", ram[2], ~wv[2]);

    // Reset while waiting for the result
    preload(1, wv[1]);
    b = bus_log.size(); done_base = done_cnt;
    bus.base_addr = 1; bus.word_count = 1; bus.start = 1'b1; bus.blk_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      if (bus.res_ready) begin ok = 1; break; end
      @(negedge clk);
    end
    check("rst_reach_wait", ok, 1);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_ncs", bus_log.size() - b, 1);
    check("midrst_ndone", done_cnt - done_base, 0);
    check("midrst_ram", ram[1], wv[1]);
    run_job(1, 1, 3, 0, -1);
    check("after_rst_ram", ram[1], ~wv[1]);
    check("after_rst_ndone", done_cnt - done_base, 1);

    check("cs_consecutive", cs_consec, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hps_data_stream_master.md
Name: hps_data_stream_master

Overview:
- FPGA-side Avalon-MM master for port s2 of the 4 x 128-bit HPS data RAM; the HPS writes plaintext blocks through s1.
- On start, reads word_count 128-bit blocks beginning at base_addr and streams each to the AES datapath over valid/ready.
- Accepts each processed block back over a second valid/ready and writes it in place at the same RAM word, then pulses done.

Parameters:
- ADDR_W, 2, RAM word-address width
- DATA_W, 128, block and RAM data width
- BE_W, 16, byteenable width (DATA_W/8)
- NUM_WORDS, 4, RAM depth in words
- READ_LATENCY, 1, cycles from read command to readdata valid (RAM registers address, unregistered q)

Ports:
- clk  in  1  single clock, shared with RAM port 2
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle job request
- base_addr  in  ADDR_W  first word of job
- word_count  in  ADDR_W+1  number of words, 0..NUM_WORDS
- address  out  ADDR_W  RAM port-2 address
- chipselect  out  1  RAM port-2 select
- write  out  1  RAM port-2 write strobe
- writedata  out  DATA_W  RAM port-2 write data
- byteenable  out  BE_W  RAM port-2 byte enables
- clken  out  1  RAM port-2 clock enable
- readdata  in  DATA_W  RAM port-2 read data
- blk_data  out  DATA_W  block to AES core
- blk_valid  out  1  blk_data valid
- blk_ready  in  1  AES core accepts block
- res_data  in  DATA_W  processed block from AES core
- res_valid  in  1  res_data valid
- res_ready  out  1  master accepts result
- busy  out  1  job in progress
- done  out  1  one-cycle job-complete pulse
- error  out  1  one-cycle pulse, coincident with done, on a rejected job

Behaviour:
- Reset values: all outputs 0 except clken=1 and byteenable=all ones. State=IDLE, counters=0. Reset mid-job aborts immediately with no further bus cycles and no done pulse.
- All outputs are registered.
- States: IDLE, RD_CMD, RD_WAIT, PRESENT, WAIT_RES, WR_CMD, FINISH.
- IDLE:
  - start=1 latches base_addr into cur_addr and word_count into remaining, and sets busy.
  - If word_count=0 or word_count>NUM_WORDS -> FINISH, with error set for >NUM_WORDS. No bus access occurs.
  - Otherwise -> RD_CMD.
- RD_CMD: one cycle with chipselect=1, write=0, address=cur_addr. Then -> RD_WAIT.
- RD_WAIT: chipselect=0. Waits READ_LATENCY cycles, captures readdata into blk_data, then -> PRESENT.
- PRESENT: blk_valid=1 and blk_data held stable until blk_ready=1. The handshake cycle clears blk_valid, then -> WAIT_RES.
- WAIT_RES:
  - res_ready=1. When res_valid=1, capture res_data into writedata and drop res_ready.
  - res_valid arriving while in PRESENT is not accepted (res_ready=0).
  - -> WR_CMD.
- WR_CMD: one cycle with chipselect=1, write=1, address=cur_addr, byteenable all ones.
  - cur_addr increments modulo NUM_WORDS (3 wraps to 0); remaining decrements.
  - remaining now 0 -> FINISH, else -> RD_CMD.
- FINISH: done=1 for one cycle (error=1 in the same cycle if the job was rejected), busy cleared, -> IDLE.
- start while busy=1 is ignored and not queued.
- Latency: start at cycle T gives a read command at T+1, blk_valid at T+3. Result handshake at cycle R gives the write at R+1. Job done is 1 cycle after the last write.
- chipselect is never asserted in two consecutive cycles. There is no read-during-write to the same port.

Decomposition:
- Package hps_data_pkg holds the state enum, NUM_WORDS, DATA_W, BE_W and the full-byteenable constant. It is shared with the AES wrapper.
- No sub-module: a single FSM plus address and count registers. An optional testbench-only RAM model is named hps_data_ram_model.

Test Plan:
- Single word: RAM[2]=0x00112233_44556677_8899AABB_CCDDEEFF, start with base_addr=2, word_count=1, blk_ready=1, result 0x69C4E0D8_6A7B0430_D8CDB780_70B4C55A after 5 cycles -> blk_data equals RAM[2] at T+3; one write to address 2 with the result; done=1 one cycle later; RAM[2] now holds the result.
- Wrap-around: base_addr=3, word_count=4 -> read/write address sequence 3,0,1,2; four blk handshakes; a single done pulse.
- Back-pressure: blk_ready=0 for 10 cycles with res_valid pulsed early -> blk_data stable throughout; early res_valid not accepted; proceeds after blk_ready=1.
- Rejected jobs: word_count=0 -> done with error=0 and zero chipselect cycles; word_count=5 -> done and error both 1, zero bus cycles.
- start while busy: second start mid-job with different base_addr -> ignored; original sequence and count completed unchanged.
- Reset mid-operation: reset asserted in WAIT_RES -> next cycle all outputs at reset values; no write issued; a subsequent start runs normally.
